// File: rtl/cpri_lane_aligner.sv
// cpri_lane_aligner: per-lane symbol FIFOs with tag-based deskew, stale-symbol drop,
// wait timeout and lock-step release of all enabled lanes.
module cpri_lane_aligner #(
  parameter int LANE = 8,
  parameter int DW = 64,
  parameter int DEPTH = 512,
  parameter int SYMB_LEN = 132,
  parameter int TMO = 4096
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [LANE-1:0]    i_lane_en,
  input  logic [LANE*DW-1:0] i_data,
  input  logic [LANE-1:0]    i_vld,
  input  logic [LANE-1:0]    i_sop,
  input  logic [LANE*12-1:0] i_tag,
  output logic [LANE*DW-1:0] o_data,
  output logic [7:0]         o_addr,
  output logic               o_vld,
  output logic               o_sop,
  output logic               o_eop,
  output logic [11:0]        o_tag,
  output logic               o_err_tmo,
  output logic [LANE-1:0]    o_drop,
  output logic [LANE-1:0]    o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 13;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] SYM_L = (AW+1)'(SYMB_LEN);
  localparam logic [7:0] CNT_LAST = 8'(SYMB_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_DROP, S_STREAM} state_t;
  state_t state, state_n;

  logic [EW-1:0] mem [LANE][DEPTH];
  logic [AW-1:0] wp [LANE];
  logic [AW-1:0] rp [LANE];
  logic [AW:0] lvl [LANE];
  logic [EW-1:0] head [LANE];
  logic [11:0] head_tag [LANE];
  logic [LANE-1:0] head_sop, nz, full, ready, wr, ovf_set, pop, en_eff, en_lat;
  logic [LANE-1:0] older, drop_n, drop_mask;
  logic [LANE*DW-1:0] data_n;
  logic [11:0] lead_tag;
  logic [7:0] cnt;
  logic [TW-1:0] tmo_cnt;
  logic all_ready, tmo_cond, tmo_fire;

  // lane a holds an older symbol than lane b when b is ahead by less than half the tag space
  function automatic logic is_older(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] d;
    d = b - a;
    return d != 12'd0 && !d[11];
  endfunction

  // enable mask is frozen while streaming so lanes keep popping in lock-step
  assign en_eff = state == S_STREAM ? en_lat : i_lane_en;
  assign wr = i_vld & i_lane_en & en_eff & ~full;
  assign ovf_set = i_vld & i_lane_en & en_eff & full;
  assign all_ready = |i_lane_en && &(ready | ~i_lane_en);
  assign tmo_cond = |(ready & i_lane_en) && !all_ready;

  always_comb begin
    for (int i = 0; i < LANE; i++) begin
      head[i] = mem[i][rp[i]];
      head_sop[i] = head[i][EW-1];
      head_tag[i] = head[i][DW +: 12];
      nz[i] = lvl[i] != '0;
      full[i] = lvl[i] == FULL_L;
      ready[i] = head_sop[i] && lvl[i] >= SYM_L;
      data_n[i*DW +: DW] = en_lat[i] ? head[i][DW-1:0] : '0;
    end
  end

  always_comb begin
    older = '0;
    lead_tag = '0;
    for (int i = LANE - 1; i >= 0; i--) begin
      if (en_lat[i]) lead_tag = head_tag[i];
      for (int j = 0; j < LANE; j++)
        if (i_lane_en[i] && i_lane_en[j] && is_older(head_tag[i], head_tag[j])) older[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk)
    for (int i = 0; i < LANE; i++)
      if (wr[i]) mem[i][wp[i]] <= {i_sop[i], i_tag[i*12 +: 12], i_data[i*DW +: DW]};

  always_ff @(posedge i_clk)
    for (int i = 0; i < LANE; i++)
      if (i_reset || !en_eff[i]) begin
        wp[i] <= '0;
        rp[i] <= '0;
        lvl[i] <= '0;
      end else begin
        wp[i] <= wp[i] + AW'(wr[i]);
        rp[i] <= rp[i] + AW'(pop[i]);
        lvl[i] <= lvl[i] + (AW+1)'(wr[i]) - (AW+1)'(pop[i]);
      end

  always_ff @(posedge i_clk) state <= i_reset ? S_IDLE : state_n;

  always_comb begin
    state_n = state;
    pop = '0;
    drop_n = '0;
    tmo_fire = 1'b0;
    case (state)
      S_IDLE: state_n = |i_lane_en ? S_WAIT : S_IDLE;
      S_WAIT: begin
        pop = i_lane_en & ~head_sop & nz;
        if (!(|i_lane_en)) state_n = S_IDLE;
        else if (all_ready) state_n = S_CHECK;
        else if (tmo_cond && tmo_cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          drop_n = ready & i_lane_en;
          state_n = S_DROP;
        end
      end
      S_CHECK: begin
        drop_n = all_ready ? older : '0;
        state_n = !all_ready ? S_WAIT : |older ? S_DROP : S_STREAM;
      end
      S_DROP: begin
        pop = drop_mask & nz;
        state_n = cnt == CNT_LAST ? S_WAIT : S_DROP;
      end
      S_STREAM: begin
        pop = en_lat & nz;
        state_n = cnt == CNT_LAST ? S_WAIT : S_STREAM;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk)
    if (i_reset) begin
      cnt <= '0;
      tmo_cnt <= '0;
      drop_mask <= '0;
      en_lat <= '0;
      o_data <= '0;
      o_addr <= '0;
      o_vld <= 1'b0;
      o_sop <= 1'b0;
      o_eop <= 1'b0;
      o_tag <= '0;
      o_err_tmo <= 1'b0;
      o_drop <= '0;
      o_ovf <= '0;
    end else begin
      cnt <= (state == S_DROP || state == S_STREAM) && cnt != CNT_LAST ? cnt + 8'd1 : '0;
      tmo_cnt <= state == S_WAIT && tmo_cond && !tmo_fire ? tmo_cnt + TW'(1) : '0;
      drop_mask <= |drop_n ? drop_n : drop_mask;
      en_lat <= state == S_STREAM ? en_lat : i_lane_en;
      o_data <= state == S_STREAM ? data_n : '0;
      o_addr <= state == S_STREAM ? cnt : '0;
      o_vld <= state == S_STREAM;
      o_sop <= state == S_STREAM && cnt == '0;
      o_eop <= state == S_STREAM && cnt == CNT_LAST;
      o_tag <= state == S_STREAM && cnt == '0 ? lead_tag : o_tag;
      o_err_tmo <= tmo_fire;
      o_drop <= drop_n;
      o_ovf <= o_ovf | ovf_set;
    end
endmodule

// File: tb/tb_cpri_lane_aligner.sv
// tb_cpri_lane_aligner: directed lane patterns; expected beats and drop events are queued
// by the stimulus and checked by an independent monitor.
module tb_cpri_lane_aligner;
  localparam int LANE = 8;
  localparam int DW = 64;
  localparam int SL = 132;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LANE-1:0] lane_en = '1;
  logic [LANE*DW-1:0] in_data = '0;
  logic [LANE-1:0] in_vld = '0;
  logic [LANE-1:0] in_sop = '0;
  logic [LANE*12-1:0] in_tag = '0;
  logic [LANE*DW-1:0] out_data;
  logic [7:0] out_addr;
  logic out_vld, out_sop, out_eop, err_tmo;
  logic [11:0] out_tag;
  logic [LANE-1:0] drop, ovf;

  cpri_lane_aligner #(.LANE(LANE), .DW(DW), .DEPTH(512), .SYMB_LEN(SL), .TMO(4096)) dut (
    .i_clk(clk), .i_reset(rst), .i_lane_en(lane_en), .i_data(in_data), .i_vld(in_vld),
    .i_sop(in_sop), .i_tag(in_tag), .o_data(out_data), .o_addr(out_addr), .o_vld(out_vld),
    .o_sop(out_sop), .o_eop(out_eop), .o_tag(out_tag), .o_err_tmo(err_tmo), .o_drop(drop),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [LANE*DW-1:0] data;
    logic [7:0] addr;
    logic sop;
    logic eop;
    logic [11:0] tag;
    int at;
  } beat_t;
  typedef struct {
    logic [LANE-1:0] mask;
    logic tmo;
  } drop_t;

  beat_t sb[$];
  drop_t dq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int st[LANE];
  int nw[LANE];
  logic [11:0] bs[LANE];
  int last_edge;

  function automatic logic [DW-1:0] dat(input int l, input logic [11:0] t, input int k);
    return {8'(l), t, 16'(k), 28'hA5C3F17};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int l, input int s, input int n, input logic [11:0] b);
    st[l] = s;
    nw[l] = n;
    bs[l] = b;
  endtask

  task automatic cfg_all(input int s, input int n, input logic [11:0] b);
    for (int l = 0; l < LANE; l++) cfg(l, s, n, b);
  endtask

  // replays the per-lane schedule: lane l sends nw[l] words starting st[l] cycles in
  task automatic drive();
    int len;
    int w;
    logic [11:0] t;
    len = 0;
    for (int l = 0; l < LANE; l++) if (nw[l] > 0 && st[l] + nw[l] > len) len = st[l] + nw[l];
    for (int c = 0; c < len; c++) begin
      for (int l = 0; l < LANE; l++) begin
        w = c - st[l];
        t = bs[l] + 12'(w / SL);
        in_vld[l] = w >= 0 && w < nw[l];
        in_sop[l] = in_vld[l] && (w % SL == 0);
        in_tag[l*12 +: 12] = in_vld[l] ? t : 12'h0;
        in_data[l*DW +: DW] = in_vld[l] ? dat(l, t, w % SL) : '0;
      end
      tick(1);
      last_edge = edge_n;
    end
    in_vld = '0;
    in_sop = '0;
  endtask

  task automatic push_sym(input logic [11:0] t, input logic [LANE-1:0] m, input int at);
    beat_t e;
    for (int k = 0; k < SL; k++) begin
      e.data = '0;
      for (int l = 0; l < LANE; l++) if (m[l]) e.data[l*DW +: DW] = dat(l, t, k);
      e.addr = 8'(k);
      e.sop = k == 0;
      e.eop = k == SL - 1;
      e.tag = t;
      e.at = k == 0 ? at : -1;
      sb.push_back(e);
    end
  endtask

  task automatic push_drop(input logic [LANE-1:0] m, input logic t);
    drop_t d;
    d.mask = m;
    d.tmo = t;
    dq.push_back(d);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || dq.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timed out: beats_left=%0d drops_left=%0d want 0/0", nm, sb.size(), dq.size());
    end
    tick(4);
  endtask

  initial begin
    beat_t e;
    drop_t d;
    forever begin
      @(posedge clk);
      #1;
      if (out_vld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat addr=%0d tag=%h want no beat", out_addr, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_addr !== e.addr || out_sop !== e.sop || out_eop !== e.eop ||
              out_tag !== e.tag || (e.at >= 0 && edge_n != e.at)) begin
            n_bad++;
            $display("FAIL beat got addr=%0d sop=%b eop=%b tag=%h edge=%0d want addr=%0d sop=%b eop=%b tag=%h edge=%0d data_ok=%b",
                     out_addr, out_sop, out_eop, out_tag, edge_n, e.addr, e.sop, e.eop, e.tag, e.at, out_data === e.data);
          end
        end
      end
      if (drop != '0 || err_tmo) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_drop got drop=%h tmo=%b want none", drop, err_tmo);
        end else begin
          d = dq.pop_front();
          if (drop !== d.mask || err_tmo !== d.tmo) begin
            n_bad++;
            $display("FAIL drop got drop=%h tmo=%b want drop=%h tmo=%b", drop, err_tmo, d.mask, d.tmo);
          end
        end
      end
    end
  end

  initial begin
    int k;
    tick(3);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    chk("rst_data", 64'(out_data == '0), 64'd1);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_flags", 64'({err_tmo, drop, ovf}), 64'd0);
    rst = 1'b0;
    tick(3);

    cfg_all(0, SL, 12'h010);
    drive();
    push_sym(12'h010, 8'hFF, last_edge + 3);
    wait_done("aligned", 400);

    cfg_all(0, SL, 12'h011);
    cfg(3, 50, SL, 12'h011);
    drive();
    push_sym(12'h011, 8'hFF, last_edge + 3);
    wait_done("skew", 400);

    cfg_all(SL, SL, 12'h010);
    cfg(5, 0, 2 * SL, 12'h00F);
    push_drop(8'h20, 1'b0);
    drive();
    push_sym(12'h010, 8'hFF, -1);
    wait_done("early_lane", 800);

    cfg_all(SL, SL, 12'h000);
    cfg(0, 0, 2 * SL, 12'hFFF);
    push_drop(8'h01, 1'b0);
    drive();
    push_sym(12'h000, 8'hFF, -1);
    wait_done("tag_wrap", 800);

    cfg_all(0, SL, 12'h030);
    cfg(2, 0, 0, 12'h030);
    push_drop(8'hFB, 1'b1);
    drive();
    wait_done("timeout", 6000);
    tick(200);
    lane_en = 8'hFB;
    tick(2);
    cfg_all(0, SL, 12'h031);
    cfg(2, 0, 0, 12'h031);
    drive();
    push_sym(12'h031, 8'hFB, last_edge + 3);
    wait_done("lane_disabled", 400);

    lane_en = 8'hFF;
    tick(2);
    cfg_all(0, 0, 12'h020);
    cfg(6, 0, 520, 12'h020);
    drive();
    chk("ovf_set", 64'(ovf), 64'h40);
    cfg_all(0, SL, 12'h020);
    cfg(6, 0, 0, 12'h020);
    drive();
    push_sym(12'h020, 8'hFF, last_edge + 3);
    k = 0;
    while (sb.size() > SL - 50 && k < 400) begin
      tick(1);
      k++;
    end
    chk("stream_started", 64'(sb.size() <= SL - 50), 64'd1);
    chk("ovf_hold", 64'(ovf), 64'h40);
    chk("vld_before_rst", 64'(out_vld), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_vld", 64'(out_vld), 64'd0);
    chk("abort_eop", 64'(out_eop), 64'd0);
    chk("abort_data", 64'(out_data == '0), 64'd1);
    chk("abort_addr_tag", 64'({out_addr, out_tag}), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    sb.delete();
    tick(20);
    chk("drops_left", 64'(dq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
